usb_host_trans_engine: RTL and testbench
========================================

Name: usb_host_trans_engine

Overview:
- usbClk-domain transaction engine for the USB host controller; the consumer of the host control register block's outputs, which are already double-synchronised into usbClk.
- Sequences SOF, SETUP/IN/OUT transactions and handshakes through the packet sender and packet receiver.
- Returns frameNum, SOFTimer, RxPktStatus, RxPID and the pulses SOFSent, transDone and clrTransReq.
- Sits between the register block and the sender/receiver.

Parameters:
- SOF_PERIOD, 48000: usbClk ticks per frame (1 ms at 48 MHz).
- SOF_GUARD, 1600: ticks before frame end in which no new transaction may start.
- RX_TIMEOUT, 72: ticks in WAIT_RESP before the response is declared timed out.

Ports:
- usbClk  in  1  clock
- rstN  in  1  async active-low reset
- transReq  in  1  level transaction request; held until clrTransReq propagates back
- TxTransType  in  2  0 SETUP, 1 IN, 2 OUTDATA0, 3 OUTDATA1
- TxAddr  in  7  device address
- TxEndP  in  4  endpoint
- TxSOFEnable  in  1  SOF generation enable
- SOFSync  in  1  start the transaction only right after a SOF
- isoEn  in  1  isochronous: no handshake phase
- preambleEn  in  1  passed through to the sender
- lineDirectControlEn  in  1  when 1, the engine starts nothing
- sendReq  out  1  level; held until sendDone
- sendPID  out  4  PID to transmit
- sendAddr  out  7  token field
- sendEndP  out  4  token field
- sendFrameNum  out  11  SOF field
- sendPreamble  out  1  = preambleEn
- sendDone  in  1  pulse: packet fully transmitted
- rxEn  out  1  high in WAIT_RESP
- rxDone  in  1  pulse: packet received
- rxPIDIn  in  4  received PID
- rxErr  in  3  {overflow, bitStuffErr, crcErr}
- frameNum  out  11  current frame number
- SOFTimer  out  16  frame tick counter
- RxPktStatus  out  8  {timeout, dataSeq, ack, stall, nak, overflow, bitStuff, crc}, bit 7 to bit 0
- RxPID  out  4  last received PID
- SOFSent  out  1  pulse
- transDone  out  1  pulse
- clrTransReq  out  1  pulse

Behaviour:
- Reset: every output is 0. The FSM goes to IDLE; sofPending = 0.
- SOFTimer:
  - Increments every cycle and wraps from SOF_PERIOD-1 to 0, independent of enables.
  - When SOFTimer == SOF_PERIOD-1 and TxSOFEnable = 1 and lineDirectControlEn = 0, set sofPending.
- IDLE priority 1: if sofPending, go to SOF.
  - Drive sendReq with sendPID = 4'h5 and sendFrameNum = frameNum.
  - On sendDone: pulse SOFSent, frameNum <= frameNum + 1 (mod 2048), clear sofPending, go to IDLE.
- IDLE priority 2: if transReq, lineDirectControlEn = 0, not (TxSOFEnable and SOFTimer >= SOF_PERIOD-SOF_GUARD), and (SOFSync = 0 or the previous cycle was SOF completion), go to TOKEN.
  - Latch the transaction type. RxPktStatus and RxPID are not cleared here.
  - When SOFSync = 1, the transaction waits for a SOF completion; if TxSOFEnable = 0 it waits forever (documented).
- TOKEN: sendReq with PID SETUP 4'hD, IN 4'h9 or OUT 4'h1, plus TxAddr and TxEndP. On sendDone:
  - IN goes to WAIT_RESP.
  - All other types go to DATA.
- DATA: sendReq with PID DATA0 4'h3 for SETUP and OUTDATA0, DATA1 4'hB for OUTDATA1. On sendDone:
  - isoEn = 1 goes to DONE.
  - Otherwise goes to WAIT_RESP.
- WAIT_RESP: rxEn = 1, with a timeout counter cleared on entry.
  - On rxDone: RxPID <= rxPIDIn, and RxPktStatus gets crc/bitStuff/overflow from rxErr, nak (PID A), stall (E), ack (2), dataSeq (PID B), timeout = 0.
  - If IN, isoEn = 0, the PID is DATA0 or DATA1 and rxErr == 0, go to ACK. Otherwise go to DONE.
  - If the counter reaches RX_TIMEOUT-1 with no rxDone: RxPktStatus = 8'h80, RxPID unchanged, go to DONE.
  - rxDone and the timeout in the same cycle: rxDone wins.
- ACK: sendReq with PID 4'h2; on sendDone go to DONE.
- DONE:
  - Pulse transDone and clrTransReq for one cycle on entry.
  - Stay in DONE until transReq == 0, then go to IDLE. This prevents a re-launch while the clear crosses domains.
  - A SOF arriving in this state is kept pending.
- sofPending set while busy: the SOF is deferred to the next IDLE, never dropped. A second wrap while already pending does not queue a second SOF.
- sendReq rises in the state-entry cycle and falls in the cycle after sendDone. A sendDone outside a send state is ignored.
- rstN asserted mid-transaction: immediate abort, no pulses.

Decomposition:
- Package usb_host_pkg holds:
  - PID constants: SOF, SETUP, IN, OUT, DATA0, DATA1, ACK, NAK, STALL.
  - Transaction-type encodings.
  - RxPktStatus bit indices.
  - The state enum.
- Sub-module usb_sof_timer holds the counter, wrap detect, sofPending and frameNum increment.

Test Plan (SOF_PERIOD = 100, SOF_GUARD = 20, RX_TIMEOUT = 10):
- SOF: TxSOFEnable = 1 from reset -> at SOFTimer = 99 sendReq with PID 5, sendFrameNum 0; after sendDone, SOFSent pulses once and frameNum = 1. frameNum 2047 wraps to 0.
- OUTDATA1 to addr 0x12 ep 3, device ACKs -> PIDs 1 then B, rxEn, RxPktStatus = 8'h20, RxPID = 2. transDone and clrTransReq pulse together; no restart until transReq drops.
- IN, device returns DATA1 clean -> ACK PID 2 sent, RxPktStatus = 8'h40, RxPID = B. With rxErr = 3'b001: no ACK sent, RxPktStatus = 8'h41.
- IN, no response -> rxDone absent for 10 cycles, RxPktStatus = 8'h80, transDone pulses.
- transReq at SOFTimer = 85 with SOF enabled -> held; SOF issued at wrap, then the transaction starts. With SOFSync = 1 and transReq at SOFTimer = 10 -> start delayed until after the next SOF.
- rstN low during DATA -> all outputs 0 asynchronously; after release the FSM is in IDLE and frameNum = 0.

Source files
------------

// File: rtl/usb_host_pkg.sv
// Shared constants, encodings and helpers for the USB host transaction engine.
// Holds the PID values, transaction-type and state enums, and status bit positions.
package usb_host_pkg;

  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  typedef enum logic [1:0] {
    TT_SETUP    = 2'd0,
    TT_IN       = 2'd1,
    TT_OUTDATA0 = 2'd2,
    TT_OUTDATA1 = 2'd3
  } trans_type_e;

  localparam int RXS_CRC      = 0;
  localparam int RXS_BITSTUFF = 1;
  localparam int RXS_OVERFLOW = 2;
  localparam int RXS_NAK      = 3;
  localparam int RXS_STALL    = 4;
  localparam int RXS_ACK      = 5;
  localparam int RXS_DATASEQ  = 6;
  localparam int RXS_TIMEOUT  = 7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SOF       = 3'd1,
    ST_TOKEN     = 3'd2,
    ST_DATA      = 3'd3,
    ST_WAIT_RESP = 3'd4,
    ST_ACK       = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  function automatic logic [3:0] token_pid(input trans_type_e tt);
    case (tt)
      TT_SETUP: token_pid = PID_SETUP;
      TT_IN:    token_pid = PID_IN;
      default:  token_pid = PID_OUT;
    endcase
  endfunction

  function automatic logic [3:0] data_pid(input trans_type_e tt);
    data_pid = (tt == TT_OUTDATA1) ? PID_DATA1 : PID_DATA0;
  endfunction

  // rx_err is {overflow, bitStuff, crc}; timeout is always clear for a real response.
  function automatic logic [7:0] rx_status(input logic [3:0] pid, input logic [2:0] rx_err);
    rx_status                = 8'h00;
    rx_status[RXS_CRC]       = rx_err[0];
    rx_status[RXS_BITSTUFF]  = rx_err[1];
    rx_status[RXS_OVERFLOW]  = rx_err[2];
    rx_status[RXS_NAK]       = (pid == PID_NAK);
    rx_status[RXS_STALL]     = (pid == PID_STALL);
    rx_status[RXS_ACK]       = (pid == PID_ACK);
    rx_status[RXS_DATASEQ]   = (pid == PID_DATA1);
    rx_status[RXS_TIMEOUT]   = 1'b0;
  endfunction

endpackage

// File: rtl/usb_sof_timer.sv
// Frame tick counter, end-of-frame guard window, pending-SOF flag and frame number.
// The counter free-runs regardless of enables; only the pending flag is gated.
module usb_sof_timer
  import usb_host_pkg::*;
#(
  parameter int SOF_PERIOD = 48000,
  parameter int SOF_GUARD  = 1600
) (
  input  logic        usbClk_i,
  input  logic        rstN_i,
  input  logic        sof_arm_i,
  input  logic        sof_done_i,
  output logic [15:0] sof_timer_o,
  output logic        sof_pending_o,
  output logic        in_guard_o,
  output logic [10:0] frame_num_o
);

  localparam logic [15:0] TIMER_LAST  = 16'(SOF_PERIOD - 1);
  localparam logic [15:0] GUARD_START = 16'(SOF_PERIOD - SOF_GUARD);

  logic [15:0] timer_q, timer_d;
  logic        pending_q, pending_d;
  logic [10:0] frame_q, frame_d;
  logic        wrap;

  always_comb begin
    wrap      = (timer_q == TIMER_LAST);
    timer_d   = wrap ? 16'd0 : timer_q + 16'd1;
    pending_d = pending_q;
    if (sof_done_i) pending_d = 1'b0;
    // A wrap already pending collapses into the one outstanding SOF.
    if (wrap && sof_arm_i) pending_d = 1'b1;
    frame_d   = sof_done_i ? frame_q + 11'd1 : frame_q;
  end

  always_ff @(posedge usbClk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      timer_q   <= 16'd0;
      pending_q <= 1'b0;
      frame_q   <= 11'd0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
    end
  end

  assign sof_timer_o   = timer_q;
  assign sof_pending_o = pending_q;
  assign in_guard_o    = (timer_q >= GUARD_START);
  assign frame_num_o   = frame_q;

endmodule

// File: rtl/usb_host_trans_engine.sv
// usbClk-domain transaction engine: sequences SOF, token, data, response and handshake
// packets between the host register block and the packet sender/receiver.
module usb_host_trans_engine
  import usb_host_pkg::*;
#(
  parameter int SOF_PERIOD = 48000,
  parameter int SOF_GUARD  = 1600,
  parameter int RX_TIMEOUT = 72
) (
  input  logic        usbClk_i,
  input  logic        rstN_i,
  input  logic        transReq_i,
  input  logic [1:0]  TxTransType_i,
  input  logic [6:0]  TxAddr_i,
  input  logic [3:0]  TxEndP_i,
  input  logic        TxSOFEnable_i,
  input  logic        SOFSync_i,
  input  logic        isoEn_i,
  input  logic        preambleEn_i,
  input  logic        lineDirectControlEn_i,
  output logic        sendReq_o,
  output logic [3:0]  sendPID_o,
  output logic [6:0]  sendAddr_o,
  output logic [3:0]  sendEndP_o,
  output logic [10:0] sendFrameNum_o,
  output logic        sendPreamble_o,
  input  logic        sendDone_i,
  output logic        rxEn_o,
  input  logic        rxDone_i,
  input  logic [3:0]  rxPIDIn_i,
  input  logic [2:0]  rxErr_i,
  output logic [10:0] frameNum_o,
  output logic [15:0] SOFTimer_o,
  output logic [7:0]  RxPktStatus_o,
  output logic [3:0]  RxPID_o,
  output logic        SOFSent_o,
  output logic        transDone_o,
  output logic        clrTransReq_o
);

  localparam int              TO_W    = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RX_TIMEOUT - 1);

  state_e          state_q, state_d;
  trans_type_e     type_q, type_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      rx_status_q, rx_status_d;
  logic [3:0]      rx_pid_q, rx_pid_d;
  logic            sof_done_q, done_pulse_q, done_pulse_d, preamble_q;

  logic            sof_done, sof_pending, in_guard, start_ok, timeout_hit, rx_ack_ok;
  logic [10:0]     frame_num;
  logic [15:0]     sof_timer;

  usb_sof_timer #(
    .SOF_PERIOD (SOF_PERIOD),
    .SOF_GUARD  (SOF_GUARD)
  ) u_sof_timer (
    .usbClk_i      (usbClk_i),
    .rstN_i        (rstN_i),
    .sof_arm_i     (TxSOFEnable_i && !lineDirectControlEn_i),
    .sof_done_i    (sof_done),
    .sof_timer_o   (sof_timer),
    .sof_pending_o (sof_pending),
    .in_guard_o    (in_guard),
    .frame_num_o   (frame_num)
  );

  assign sof_done    = (state_q == ST_SOF) && sendDone_i;
  // SOFSync with SOF disabled never sees sof_done_q and so waits indefinitely.
  assign start_ok    = transReq_i && !lineDirectControlEn_i
                       && !(TxSOFEnable_i && in_guard)
                       && (!SOFSync_i || sof_done_q);
  assign timeout_hit = (to_cnt_q == TO_LAST);
  assign rx_ack_ok   = (type_q == TT_IN) && !isoEn_i && (rxErr_i == 3'b000)
                       && ((rxPIDIn_i == PID_DATA0) || (rxPIDIn_i == PID_DATA1));

  always_ff @(posedge usbClk_i or negedge rstN_i) begin
    if (!rstN_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sof_pending && !lineDirectControlEn_i) state_d = ST_SOF;
        else if (start_ok)                          state_d = ST_TOKEN;
      end
      ST_SOF:   if (sendDone_i) state_d = ST_IDLE;
      ST_TOKEN: if (sendDone_i) state_d = (type_q == TT_IN) ? ST_WAIT_RESP : ST_DATA;
      ST_DATA:  if (sendDone_i) state_d = isoEn_i ? ST_DONE : ST_WAIT_RESP;
      ST_WAIT_RESP: begin
        if (rxDone_i)         state_d = rx_ack_ok ? ST_ACK : ST_DONE;
        else if (timeout_hit) state_d = ST_DONE;
      end
      ST_ACK:   if (sendDone_i)  state_d = ST_DONE;
      ST_DONE:  if (!transReq_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sendReq_o      = 1'b0;
    sendPID_o      = 4'h0;
    sendAddr_o     = 7'h00;
    sendEndP_o     = 4'h0;
    sendFrameNum_o = 11'h000;
    rxEn_o         = 1'b0;
    case (state_q)
      ST_SOF: begin
        sendReq_o      = 1'b1;
        sendPID_o      = PID_SOF;
        sendFrameNum_o = frame_num;
      end
      ST_TOKEN: begin
        sendReq_o  = 1'b1;
        sendPID_o  = token_pid(type_q);
        sendAddr_o = TxAddr_i;
        sendEndP_o = TxEndP_i;
      end
      ST_DATA: begin
        sendReq_o = 1'b1;
        sendPID_o = data_pid(type_q);
      end
      ST_WAIT_RESP: rxEn_o = 1'b1;
      ST_ACK: begin
        sendReq_o = 1'b1;
        sendPID_o = PID_ACK;
      end
      default: ;
    endcase
  end

  always_comb begin
    type_d       = type_q;
    to_cnt_d     = '0;
    rx_status_d  = rx_status_q;
    rx_pid_d     = rx_pid_q;
    done_pulse_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    if ((state_q == ST_IDLE) && (state_d == ST_TOKEN)) type_d = trans_type_e'(TxTransType_i);
    if (state_q == ST_WAIT_RESP) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
      if (rxDone_i) begin
        rx_pid_d    = rxPIDIn_i;
        rx_status_d = rx_status(rxPIDIn_i, rxErr_i);
      end else if (timeout_hit) begin
        rx_status_d = 8'h80;
      end
    end
  end

  always_ff @(posedge usbClk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      type_q       <= TT_SETUP;
      to_cnt_q     <= '0;
      rx_status_q  <= 8'h00;
      rx_pid_q     <= 4'h0;
      sof_done_q   <= 1'b0;
      done_pulse_q <= 1'b0;
      preamble_q   <= 1'b0;
    end else begin
      type_q       <= type_d;
      to_cnt_q     <= to_cnt_d;
      rx_status_q  <= rx_status_d;
      rx_pid_q     <= rx_pid_d;
      sof_done_q   <= sof_done;
      done_pulse_q <= done_pulse_d;
      preamble_q   <= preambleEn_i;
    end
  end

  assign sendPreamble_o = preamble_q;
  assign frameNum_o     = frame_num;
  assign SOFTimer_o     = sof_timer;
  assign RxPktStatus_o  = rx_status_q;
  assign RxPID_o        = rx_pid_q;
  assign SOFSent_o      = sof_done_q;
  assign transDone_o    = done_pulse_q;
  assign clrTransReq_o  = done_pulse_q;

endmodule

// File: tb/tb_usb_host_trans_engine.sv
// Directed bench for usb_host_trans_engine with a small frame (100 ticks, guard 20, timeout 10).
// The bench plays the packet sender and receiver by hand at the falling clock edge.
module tb_usb_host_trans_engine;

  logic        usbClk = 1'b0;
  logic        rstN = 1'b0;
  logic        transReq = 1'b0;
  logic [1:0]  TxTransType = 2'd0;
  logic [6:0]  TxAddr = 7'h00;
  logic [3:0]  TxEndP = 4'h0;
  logic        TxSOFEnable = 1'b1;
  logic        SOFSync = 1'b0;
  logic        isoEn = 1'b0;
  logic        preambleEn = 1'b0;
  logic        lineDirectControlEn = 1'b0;
  logic        sendDone = 1'b0;
  logic        rxDone = 1'b0;
  logic [3:0]  rxPIDIn = 4'h0;
  logic [2:0]  rxErr = 3'b000;

  logic        sendReq_o, sendPreamble_o, rxEn_o, SOFSent_o, transDone_o, clrTransReq_o;
  logic [3:0]  sendPID_o, sendEndP_o, RxPID_o;
  logic [6:0]  sendAddr_o;
  logic [10:0] sendFrameNum_o, frameNum_o;
  logic [15:0] SOFTimer_o;
  logic [7:0]  RxPktStatus_o;

  int n_checks = 0;
  int n_pass   = 0;

  usb_host_trans_engine #(
    .SOF_PERIOD (100),
    .SOF_GUARD  (20),
    .RX_TIMEOUT (10)
  ) dut (
    .usbClk_i              (usbClk),
    .rstN_i                (rstN),
    .transReq_i            (transReq),
    .TxTransType_i         (TxTransType),
    .TxAddr_i              (TxAddr),
    .TxEndP_i              (TxEndP),
    .TxSOFEnable_i         (TxSOFEnable),
    .SOFSync_i             (SOFSync),
    .isoEn_i               (isoEn),
    .preambleEn_i          (preambleEn),
    .lineDirectControlEn_i (lineDirectControlEn),
    .sendReq_o             (sendReq_o),
    .sendPID_o             (sendPID_o),
    .sendAddr_o            (sendAddr_o),
    .sendEndP_o            (sendEndP_o),
    .sendFrameNum_o        (sendFrameNum_o),
    .sendPreamble_o        (sendPreamble_o),
    .sendDone_i            (sendDone),
    .rxEn_o                (rxEn_o),
    .rxDone_i              (rxDone),
    .rxPIDIn_i             (rxPIDIn),
    .rxErr_i               (rxErr),
    .frameNum_o            (frameNum_o),
    .SOFTimer_o            (SOFTimer_o),
    .RxPktStatus_o         (RxPktStatus_o),
    .RxPID_o               (RxPID_o),
    .SOFSent_o             (SOFSent_o),
    .transDone_o           (transDone_o),
    .clrTransReq_o         (clrTransReq_o)
  );

  always #5 usbClk = ~usbClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_req(input string tag, input int bound);
    bit found = 0;
    for (int i = 0; i < bound; i++) begin
      if (sendReq_o) begin found = 1; break; end
      @(negedge usbClk);
    end
    check({tag, "_req"}, 32'(found), 32'd1);
  endtask

  task automatic send_done();
    sendDone = 1'b1;
    @(negedge usbClk);
    sendDone = 1'b0;
  endtask

  task automatic expect_send(input string tag, input logic [3:0] pid);
    wait_req(tag, 200);
    check({tag, "_pid"}, 32'(sendPID_o), 32'(pid));
    send_done();
  endtask

  task automatic wait_rx(input string tag);
    bit found = 0;
    for (int i = 0; i < 50; i++) begin
      if (rxEn_o) begin found = 1; break; end
      @(negedge usbClk);
    end
    check({tag, "_rxen"}, 32'(found), 32'd1);
  endtask

  task automatic respond(input logic [3:0] pid, input logic [2:0] err);
    rxDone  = 1'b1;
    rxPIDIn = pid;
    rxErr   = err;
    @(negedge usbClk);
    rxDone  = 1'b0;
    rxErr   = 3'b000;
  endtask

  // Steps to a given frame tick, acknowledging any SOF the engine issues on the way.
  task automatic wait_timer(input logic [15:0] val);
    bit found = 0;
    for (int i = 0; i < 300; i++) begin
      if (SOFTimer_o == val) begin found = 1; break; end
      sendDone = sendReq_o && (sendPID_o == 4'h5);
      @(negedge usbClk);
      sendDone = 1'b0;
    end
    check("wait_timer", 32'(found), 32'd1);
  endtask

  task automatic count_req(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge usbClk);
      if (sendReq_o) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int rx_cycles;
    bit done_seen;

    // reset state
    #1;
    check("rst_sendReq",  32'(sendReq_o), 32'd0);
    check("rst_timer",    32'(SOFTimer_o), 32'd0);
    check("rst_frame",    32'(frameNum_o), 32'd0);
    check("rst_status",   32'(RxPktStatus_o), 32'd0);
    check("rst_transDone", 32'(transDone_o), 32'd0);
    repeat (2) @(negedge usbClk);
    rstN = 1'b1;

    // first SOF carries frame 0, then frame counter advances
    wait_req("sof", 200);
    check("sof_pid", 32'(sendPID_o), 32'h5);
    check("sof_fn",  32'(sendFrameNum_o), 32'd0);
    send_done();
    check("sof_sent",  32'(SOFSent_o), 32'd1);
    check("sof_frame", 32'(frameNum_o), 32'd1);
    @(negedge usbClk);
    check("sof_sent_once", 32'(SOFSent_o), 32'd0);
    TxSOFEnable = 1'b0;

    // OUTDATA1 to 0x12/3, device ACKs
    TxTransType = 2'd3; TxAddr = 7'h12; TxEndP = 4'h3; preambleEn = 1'b1;
    transReq = 1'b1;
    wait_req("out_tok", 200);
    check("out_tok_pid",  32'(sendPID_o), 32'h1);
    check("out_tok_addr", 32'(sendAddr_o), 32'h12);
    check("out_tok_ep",   32'(sendEndP_o), 32'h3);
    check("out_preamble", 32'(sendPreamble_o), 32'd1);
    send_done();
    expect_send("out_data", 4'hB);
    wait_rx("out");
    respond(4'h2, 3'b000);
    check("out_transDone", 32'(transDone_o), 32'd1);
    check("out_clrReq",    32'(clrTransReq_o), 32'd1);
    check("out_status",    32'(RxPktStatus_o), 32'h20);
    check("out_rxpid",     32'(RxPID_o), 32'h2);
    @(negedge usbClk);
    check("out_done_pulse", 32'(transDone_o), 32'd0);
    count_req("out_no_relaunch", 6);
    transReq = 1'b0; preambleEn = 1'b0;
    repeat (2) @(negedge usbClk);

    // IN, clean DATA1 -> host ACK
    TxTransType = 2'd1;
    transReq = 1'b1;
    expect_send("in_tok", 4'h9);
    wait_rx("in");
    respond(4'hB, 3'b000);
    wait_req("in_ack", 20);
    check("in_ack_pid", 32'(sendPID_o), 32'h2);
    check("in_status",  32'(RxPktStatus_o), 32'h40);
    check("in_rxpid",   32'(RxPID_o), 32'hB);
    send_done();
    check("in_transDone", 32'(transDone_o), 32'd1);
    transReq = 1'b0;
    repeat (2) @(negedge usbClk);

    // IN with CRC error -> no ACK
    transReq = 1'b1;
    expect_send("inerr_tok", 4'h9);
    wait_rx("inerr");
    respond(4'hB, 3'b001);
    check("inerr_transDone", 32'(transDone_o), 32'd1);
    check("inerr_noack",     32'(sendReq_o), 32'd0);
    check("inerr_status",    32'(RxPktStatus_o), 32'h41);
    transReq = 1'b0;
    repeat (2) @(negedge usbClk);

    // IN, silent device -> timeout after 10 cycles of rxEn
    transReq = 1'b1;
    expect_send("to_tok", 4'h9);
    rx_cycles = 0; done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (transDone_o) begin done_seen = 1; break; end
      if (rxEn_o) rx_cycles++;
      @(negedge usbClk);
    end
    check("to_done",   32'(done_seen), 32'd1);
    check("to_cycles", 32'(rx_cycles), 32'd10);
    check("to_status", 32'(RxPktStatus_o), 32'h80);
    check("to_rxpid",  32'(RxPID_o), 32'hB);
    transReq = 1'b0;
    repeat (2) @(negedge usbClk);

    // request inside guard window: SOF goes first
    wait_timer(16'd50);
    TxSOFEnable = 1'b1;
    wait_timer(16'd85);
    TxTransType = 2'd2;
    transReq = 1'b1;
    wait_req("g_first", 200);
    check("g_first_pid", 32'(sendPID_o), 32'h5);
    send_done();
    expect_send("g_tok", 4'h1);
    expect_send("g_data", 4'h3);
    wait_rx("g");
    respond(4'hA, 3'b000);
    check("g_transDone", 32'(transDone_o), 32'd1);
    check("g_status",    32'(RxPktStatus_o), 32'h08);
    transReq = 1'b0;
    repeat (2) @(negedge usbClk);

    // SOFSync: request mid-frame waits for the next SOF
    wait_timer(16'd10);
    SOFSync = 1'b1; TxTransType = 2'd1;
    transReq = 1'b1;
    count_req("sync_held", 20);
    wait_req("sync_sof", 150);
    check("sync_sof_pid", 32'(sendPID_o), 32'h5);
    send_done();
    expect_send("sync_tok", 4'h9);
    wait_rx("sync");
    respond(4'hE, 3'b000);
    check("sync_transDone", 32'(transDone_o), 32'd1);
    check("sync_status",    32'(RxPktStatus_o), 32'h10);
    check("sync_rxpid",     32'(RxPID_o), 32'hE);
    transReq = 1'b0; SOFSync = 1'b0;
    repeat (2) @(negedge usbClk);

    // line direct control blocks any launch
    wait_timer(16'd30);
    TxSOFEnable = 1'b0;
    lineDirectControlEn = 1'b1;
    transReq = 1'b1;
    count_req("ldc_blocked", 10);
    transReq = 1'b0;
    @(negedge usbClk);
    lineDirectControlEn = 1'b0;

    // reset during DATA
    TxTransType = 2'd2;
    transReq = 1'b1;
    expect_send("rst_tok", 4'h1);
    wait_req("rst_data", 20);
    check("rst_data_pid", 32'(sendPID_o), 32'h3);
    #2 rstN = 1'b0;
    #1;
    check("arst_sendReq", 32'(sendReq_o), 32'd0);
    check("arst_pid",     32'(sendPID_o), 32'd0);
    check("arst_frame",   32'(frameNum_o), 32'd0);
    check("arst_timer",   32'(SOFTimer_o), 32'd0);
    check("arst_status",  32'(RxPktStatus_o), 32'd0);
    check("arst_rxpid",   32'(RxPID_o), 32'd0);
    transReq = 1'b0;
    @(negedge usbClk);
    rstN = 1'b1;
    count_req("post_rst_idle", 3);
    check("post_rst_frame", 32'(frameNum_o), 32'd0);
    TxTransType = 2'd1;
    transReq = 1'b1;
    wait_req("post_rst_tok", 20);
    check("post_rst_tok_pid", 32'(sendPID_o), 32'h9);
    transReq = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
